// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one SPI RAM between instruction-fetch and load/store ports.
// Each grant becomes one 40-bit mode-0 SPI transaction: command, address, data.
module spi_ram_arbiter #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ack,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        spi_select,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      r_state;
    logic [38:0] r_tx;
    logic [14:0] r_rx;
    logic [5:0]  r_bit;
    logic        r_phase;
    logic        r_gnt_data;
    logic        r_last_data;
    logic        r_we;
    logic        r_select;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_busy;
    logic        r_fetch_ack;
    logic        r_data_ack;
    logic [15:0] r_rdata;

    logic        w_pick_data;
    logic [39:0] w_load;
    logic [15:0] w_rx_next;

    always_comb begin
        // Data wins when alone, or on a tie when fetch held the last grant.
        w_pick_data = data_req && (!fetch_req || !r_last_data);
        if (w_pick_data) begin
            w_load = {(data_we ? CMD_WRITE : CMD_READ), data_addr,
                      (data_we ? data_wdata : 16'h0000)};
        end else begin
            w_load = {CMD_READ, fetch_addr, 16'h0000};
        end
        w_rx_next = {r_rx, spi_miso};
    end

    // r_mosi holds the current MSB of the 40-bit frame; r_tx holds the remaining 39 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit       <= '0;
            r_phase     <= 1'b0;
            r_gnt_data  <= 1'b0;
            r_last_data <= 1'b1;
            r_we        <= 1'b0;
            r_select    <= 1'b1;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_ack <= 1'b0;
            r_data_ack  <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fetch_ack <= 1'b0;
                    r_data_ack  <= 1'b0;
                    if (fetch_req || data_req) begin
                        r_gnt_data  <= w_pick_data;
                        r_last_data <= w_pick_data;
                        r_we        <= w_pick_data && data_we;
                        r_tx        <= w_load[38:0];
                        r_mosi      <= w_load[39];
                        r_bit       <= 6'd39;
                        r_phase     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_select    <= 1'b0;
                        r_sclk      <= 1'b0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!r_phase) begin
                        r_sclk  <= 1'b1;
                        r_phase <= 1'b1;
                    end else begin
                        r_sclk  <= 1'b0;
                        r_phase <= 1'b0;
                        r_rx    <= w_rx_next[14:0];
                        r_tx    <= {r_tx[37:0], 1'b0};
                        if (r_bit == 6'd0) begin
                            r_state     <= DONE;
                            r_select    <= 1'b1;
                            r_mosi      <= 1'b0;
                            r_busy      <= 1'b0;
                            r_fetch_ack <= !r_gnt_data;
                            r_data_ack  <= r_gnt_data;
                            if (!r_we) begin
                                r_rdata <= w_rx_next;
                            end
                        end else begin
                            r_bit  <= r_bit - 6'd1;
                            r_mosi <= r_tx[38];
                        end
                    end
                end
                DONE: begin
                    r_fetch_ack <= 1'b0;
                    r_data_ack  <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fetch_ack  = r_fetch_ack;
    assign data_ack   = r_data_ack;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign spi_select = r_select;
    assign spi_clk    = r_sclk;
    assign spi_mosi   = r_mosi;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: vector table of single transactions plus
// round-robin and mid-transfer reset sequences, with a cycle-sampled SPI RAM model.
module tb_spi_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_ack;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] data_wdata = '0;
    logic        data_ack;
    logic [15:0] rdata;
    logic        busy;
    logic        spi_select;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_ram_arbiter #(
        .CMD_READ (8'h03),
        .CMD_WRITE(8'h02)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_ack (fetch_ack),
        .data_req  (data_req),
        .data_we   (data_we),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_ack  (data_ack),
        .rdata     (rdata),
        .busy      (busy),
        .spi_select(spi_select),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SPI RAM model and protocol monitor, sampled mid-cycle
    logic [39:0] resp = '0;
    logic [39:0] mosi_cap = '0;
    logic        mosi_at_rise = 1'b0;
    logic        prev_sel = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        abort = 1'b0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          gap_cnt = 0;
    int          last_gap = 0;

    always @(negedge clk) begin
        if (prev_sel && !spi_select) begin
            last_gap = gap_cnt;
            gap_cnt  = 0;
            rise_cnt = 0;
            fall_cnt = 0;
            spi_miso = resp[39];
        end
        if (!spi_select && !prev_sclk && spi_clk) begin
            mosi_cap     = {mosi_cap[38:0], spi_mosi};
            mosi_at_rise = spi_mosi;
            rise_cnt++;
        end
        if (!spi_select && prev_sclk && !spi_clk) begin
            fall_cnt++;
            if (fall_cnt < 40) spi_miso = resp[39 - fall_cnt];
        end
        if (!spi_select && spi_clk === 1'b1) check("mosi_stable", spi_mosi, mosi_at_rise);
        if (!prev_sel && spi_select && !abort) check("sclk_rises_per_txn", rise_cnt, 40);
        if (fetch_ack && data_ack) check("acks_exclusive", 2'b11, 2'b01);
        if (spi_select) gap_cnt++;
        prev_sel  = spi_select;
        prev_sclk = spi_clk;
    end

    task automatic wait_ack(output int cnt, output logic fa, output logic da);
        cnt = 0;
        fa  = 1'b0;
        da  = 1'b0;
        while (cnt < 300 && !fa && !da) begin
            @(posedge clk);
            #1;
            cnt++;
            fa = fetch_ack;
            da = data_ack;
        end
    endtask

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] miso;
        logic [39:0] exp_mosi;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   cnt;
        int   waited;
        int   acks;
        logic fa;
        logic da;
        logic rr_exp[3];

        vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, {8'h03, 16'h1234, 16'h0000}, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFE, 16'hA55A, 16'h1357, {8'h02, 16'hFFFE, 16'hA55A}, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 16'h0100, 16'h7777, 16'h8001, {8'h03, 16'h0100, 16'h0000}, 16'h8001};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h7E81, {8'h03, 16'hFFFF, 16'h0000}, 16'h7E81};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0F0F, {8'h02, 16'h0000, 16'hFFFF}, 16'h7E81};

        repeat (3) @(posedge clk);
        #1;
        check("rst_select", spi_select, 1'b1);
        check("rst_sclk", spi_clk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_fetch_ack", fetch_ack, 1'b0);
        check("rst_data_ack", data_ack, 1'b0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            resp = {24'hA5C33C, vecs[i].miso};
            if (vecs[i].is_fetch) begin
                fetch_req  = 1'b1;
                fetch_addr = vecs[i].addr;
            end else begin
                data_req   = 1'b1;
                data_we    = vecs[i].we;
                data_addr  = vecs[i].addr;
                data_wdata = vecs[i].wdata;
            end
            waited = 0;
            do begin
                @(posedge clk);
                #1;
                waited++;
            end while (!busy && waited < 10);
            check("grant_wait", waited, (i == 0) ? 1 : 2);
            wait_ack(cnt, fa, da);
            check("ack_latency", cnt, 80);
            check("fetch_ack", fa, vecs[i].is_fetch);
            check("data_ack", da, !vecs[i].is_fetch);
            check("rdata", rdata, vecs[i].exp_rdata);
            check("mosi_stream", mosi_cap, vecs[i].exp_mosi);
            check("busy_at_ack", busy, 1'b0);
            if (i > 0) check("select_gap", last_gap, 2);
            fetch_req = 1'b0;
            data_req  = 1'b0;
        end

        // Round-robin from reset: both held, grants go fetch, data, fetch
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp       = {24'hA5C33C, 16'h4321};
        fetch_addr = 16'h0040;
        data_we    = 1'b0;
        data_addr  = 16'h0080;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        rr_exp[0] = 1'b1;
        rr_exp[1] = 1'b0;
        rr_exp[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(cnt, fa, da);
            check("rr_ack_seen", fa | da, 1'b1);
            check("rr_order_fetch", fa, rr_exp[k]);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        check("rr_rdata", rdata, 16'h4321);

        // Reset in the middle of a fetch
        repeat (4) @(posedge clk);
        #1;
        fetch_addr = 16'h5555;
        fetch_req  = 1'b1;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!busy && waited < 10);
        check("mid_grant", busy, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check("mid_select_low", spi_select, 1'b0);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_select", spi_select, 1'b1);
        check("abort_sclk", spi_clk, 1'b0);
        check("abort_mosi", spi_mosi, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_fetch_ack", fetch_ack, 1'b0);
        check("abort_data_ack", data_ack, 1'b0);
        check("abort_rdata", rdata, 16'h0000);
        fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (fetch_ack || data_ack || busy) acks++;
        end
        check("post_abort_quiet", acks, 0);
        abort = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
